muldiv_scheduler: RTL and testbench

Sequencing controller and result store for the multiply/divide unit of the P7 pipeline. Accepts mult/multu/div/divu/madd/mthi/mtlo operations issued from EX, runs a fixed-latency busy counter, commits HI/LO at completion and generates the ID-stage stall for any mult/div-class instruction that arrives while the unit is occupied. Also suppresses issue when an exception or interrupt flushes the issuing instruction.

---
 rtl/muldiv_scheduler_if.sv | 28 ++
 rtl/muldiv_scheduler.sv | 158 +++++++++++++++
 tb/tb_muldiv_scheduler.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_scheduler_if.sv
// Issue/read bundle between the EX stage and the mul/div scheduler.
// master drives the request side, slave returns busy/stall and HI/LO.
interface muldiv_scheduler_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        id_muldiv;
  logic        rd_sel;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rd_data;

  modport master (
    output start, op, A, B, flush,
    output id_muldiv, rd_sel,
    input  busy, stall, HI, LO, rd_data
  );

  modport slave (
    input  start, op, A, B, flush,
    input  id_muldiv, rd_sel,
    output busy, stall, HI, LO, rd_data
  );
endinterface

// File: rtl/muldiv_scheduler.sv
// Mul/div sequencing and HI/LO store: fixed-latency busy window,
// pending result committed when the counter expires, ID-stage stall.
module muldiv_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  muldiv_scheduler_if.slave bus
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] hi_q, hi_n;
  logic [31:0] lo_q, lo_n;
  logic [31:0] ph, ph_n;
  logic [31:0] pl, pl_n;
  logic        nw, nw_n;

  logic        busy;
  logic        issue;
  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic        is_mt;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        madd_sum;
  logic [31:0]        q_res;
  logic [31:0]        r_res;
  logic               b_zero;

  assign busy   = (state == RUN);
  assign issue  = bus.start & ~bus.flush & (bus.op != OP_NONE);
  assign accept = issue & ~busy;

  assign is_mul = (bus.op == OP_MULT) | (bus.op == OP_MULTU)
                | (bus.op == OP_MADD);
  assign is_div = (bus.op == OP_DIV) | (bus.op == OP_DIVU);
  assign is_mt  = (bus.op == OP_MTHI) | (bus.op == OP_MTLO);

  assign prod_s   = $signed(bus.A) * $signed(bus.B);
  assign prod_u   = {32'd0, bus.A} * {32'd0, bus.B};
  assign madd_sum = {hi_q, lo_q} + prod_s;
  assign b_zero   = (bus.B == 32'd0);

  // Divider output is only meaningful when B is non-zero.
  always_comb begin
    q_res = 32'd0;
    r_res = 32'd0;
    if (!b_zero) begin
      if (bus.op == OP_DIV) begin
        q_res = $signed(bus.A) / $signed(bus.B);
        r_res = $signed(bus.A) % $signed(bus.B);
      end else begin
        q_res = bus.A / bus.B;
        r_res = bus.A % bus.B;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_q;
    lo_n    = lo_q;
    ph_n    = ph;
    pl_n    = pl;
    nw_n    = nw;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mul: begin
              unique case (bus.op)
                OP_MULT:  {ph_n, pl_n} = prod_s;
                OP_MULTU: {ph_n, pl_n} = prod_u;
                default:  {ph_n, pl_n} = madd_sum;
              endcase
              nw_n    = 1'b0;
              cnt_n   = CW'(MULT_CYCLES);
              state_n = RUN;
            end
            is_div: begin
              ph_n    = r_res;
              pl_n    = q_res;
              nw_n    = b_zero;
              cnt_n   = CW'(DIV_CYCLES);
              state_n = RUN;
            end
            is_mt: begin
              if (bus.op == OP_MTHI) hi_n = bus.A;
              else                   lo_n = bus.A;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          if (!nw) begin
            hi_n = ph;
            lo_n = pl;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      ph    <= 32'd0;
      pl    <= 32'd0;
      nw    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      ph    <= ph_n;
      pl    <= pl_n;
      nw    <= nw_n;
    end
  end

  assign bus.busy    = busy;
  assign bus.stall   = bus.id_muldiv & (busy | issue);
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Scoreboard bench for muldiv_scheduler: stimulus queues expected
// commits, a monitor checks them when busy drops.
module tb_muldiv_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_scheduler_if bus ();

  muldiv_scheduler #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bcnt  = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(int cyc, logic [31:0] hi, logic [31:0] lo);
    exp_t e;
    e.cyc = cyc;
    e.hi  = hi;
    e.lo  = lo;
    sb.push_back(e);
  endtask

  task automatic issue(logic [2:0] op, logic [31:0] a,
                       logic [31:0] b, logic fl);
    @(negedge clk);
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.flush = fl;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.flush = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: busy stuck high want low");
    end
  endtask

  // Monitor: a busy window ending outside reset is a commit.
  always @(negedge clk) begin
    if (reset) begin
      bcnt = 0;
    end else if (bus.busy) begin
      bcnt++;
    end else if (bcnt != 0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: unexpected commit after %0d cycles",
                 bcnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("commit_cycles", 32'(bcnt), 32'(e.cyc));
        check("commit_hi", bus.HI, e.hi);
        check("commit_lo", bus.LO, e.lo);
      end
      bcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset)
      assert (!(bus.start && bus.busy))
        else $error("start issued while busy");
  end

  initial begin
    int scnt;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = 3'd0;
    bus.A         = 32'd0;
    bus.B         = 32'd0;
    bus.flush     = 1'b0;
    bus.id_muldiv = 1'b0;
    bus.rd_sel    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    reset = 1'b0;

    push(5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    issue(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    wait_idle();
    check("mult_rd_lo", bus.rd_data, 32'hFFFFFFF1);

    push(5, 32'h00000004, 32'hFFFFFFF1);
    issue(3'd2, 32'hFFFFFFFD, 32'd5, 1'b0);
    wait_idle();

    push(10, 32'd1, 32'd3);
    issue(3'd4, 32'd7, 32'd2, 1'b0);
    @(negedge clk);
    check("stall_no_id", 32'(bus.stall), 32'd0);
    wait_idle();

    push(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle();

    issue(3'd5, 32'h11, 32'd0, 1'b0);
    check("mthi_hi", bus.HI, 32'h11);
    issue(3'd6, 32'h22, 32'd0, 1'b0);
    check("mtlo_lo", bus.LO, 32'h22);
    push(10, 32'h11, 32'h22);
    issue(3'd3, 32'd99, 32'd0, 1'b0);
    wait_idle();

    push(5, 32'd0, 32'd42);
    @(negedge clk);
    bus.op        = 3'd1;
    bus.A         = 32'd6;
    bus.B         = 32'd7;
    bus.start     = 1'b1;
    bus.id_muldiv = 1'b1;
    #1;
    check("stall_issue", 32'(bus.stall), 32'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    scnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.stall) scnt++;
      else break;
    end
    check("stall_cycles", 32'(scnt), 32'd5);
    check("mflo_rd", bus.rd_data, 32'd42);
    bus.id_muldiv = 1'b0;

    issue(3'd1, 32'd9, 32'd9, 1'b1);
    check("flush_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("flush_busy2", 32'(bus.busy), 32'd0);
    check("flush_hi", bus.HI, 32'd0);
    check("flush_lo", bus.LO, 32'd42);

    issue(3'd5, 32'h1234, 32'd0, 1'b0);
    bus.rd_sel = 1'b1;
    #1;
    check("mthi_rd", bus.rd_data, 32'h1234);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    bus.rd_sel = 1'b0;

    issue(3'd5, 32'd0, 32'd0, 1'b0);
    issue(3'd6, 32'd1, 32'd0, 1'b0);
    push(5, 32'd0, 32'd7);
    issue(3'd7, 32'd2, 32'd3, 1'b0);
    wait_idle();

    issue(3'd3, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.id_muldiv = 1'b1;
    #1;
    check("stall_busy", 32'(bus.stall), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_stall", 32'(bus.stall), 32'd0);
    check("mid_rst_hi", bus.HI, 32'd0);
    check("mid_rst_lo", bus.LO, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.id_muldiv = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_hi", bus.HI, 32'd0);
    check("post_rst_lo", bus.LO, 32'd0);

    repeat (2) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
